// File: rtl/bp_me_burst_mem_responder.sv
// rtl/bp_me_burst_mem_responder.sv - burst memory responder backed by a dword store
module bp_me_burst_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int dword_width_p   = 64,
    parameter int payload_width_p = 16,
    parameter int els_p           = 64,
    localparam int hdr_w          = 7 + paddr_width_p + payload_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [hdr_w-1:0]         mem_cmd_header_i,
    input  logic                     mem_cmd_header_v_i,
    output logic                     mem_cmd_header_ready_o,
    input  logic [dword_width_p-1:0] mem_cmd_data_i,
    input  logic                     mem_cmd_data_v_i,
    output logic                     mem_cmd_data_ready_o,
    output logic [hdr_w-1:0]         mem_resp_header_o,
    output logic                     mem_resp_header_v_o,
    input  logic                     mem_resp_header_ready_i,
    output logic [dword_width_p-1:0] mem_resp_data_o,
    output logic                     mem_resp_data_v_o,
    input  logic                     mem_resp_data_ready_i
);

    localparam int lg_els = $clog2(els_p);

    typedef enum logic [1:0] {IDLE, WR_DATA, RESP_HDR, RD_DATA} state_t;

    state_t                   state, state_n;
    logic [hdr_w-1:0]         hdr_r;
    logic [4:0]               cnt;
    logic [4:0]               last_cnt;
    logic [dword_width_p-1:0] store [els_p];
    logic [lg_els-1:0]        idx;
    logic [3:0]               msg_type;
    logic [2:0]               size;
    logic                     last_beat;
    logic                     cmd_hdr_xfer, cmd_data_xfer, resp_hdr_xfer, resp_data_xfer;

    assign msg_type  = hdr_r[3:0];
    assign size      = hdr_r[4+paddr_width_p +: 3];
    // Byte offset within the dword (addr[2:0]) plays no part in indexing.
    assign idx       = hdr_r[7 +: lg_els] + lg_els'(cnt);
    assign last_beat = (cnt == last_cnt);

    always_comb begin
        last_cnt = 5'd0;
        case (size)
            3'd4:    last_cnt = 5'd1;
            3'd5:    last_cnt = 5'd3;
            3'd6:    last_cnt = 5'd7;
            3'd7:    last_cnt = 5'd15;
            default: last_cnt = 5'd0;
        endcase
    end

    assign mem_resp_header_o = hdr_r;
    assign mem_resp_data_o   = store[idx];

    assign cmd_hdr_xfer   = mem_cmd_header_v_i & mem_cmd_header_ready_o;
    assign cmd_data_xfer  = mem_cmd_data_v_i & mem_cmd_data_ready_o;
    assign resp_hdr_xfer  = mem_resp_header_v_o & mem_resp_header_ready_i;
    assign resp_data_xfer = mem_resp_data_v_o & mem_resp_data_ready_i;

    always_comb begin
        state_n                = state;
        mem_cmd_header_ready_o = 1'b0;
        mem_cmd_data_ready_o   = 1'b0;
        mem_resp_header_v_o    = 1'b0;
        mem_resp_data_v_o      = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so nothing is offered while reset is held.
                mem_cmd_header_ready_o = reset_n_i;
                if (mem_cmd_header_v_i && reset_n_i)
                    state_n = (mem_cmd_header_i[3:0] == 4'd1) ? WR_DATA : RESP_HDR;
            end
            WR_DATA: begin
                mem_cmd_data_ready_o = 1'b1;
                if (mem_cmd_data_v_i && last_beat)
                    state_n = RESP_HDR;
            end
            RESP_HDR: begin
                mem_resp_header_v_o = 1'b1;
                if (mem_resp_header_ready_i)
                    state_n = (msg_type == 4'd0) ? RD_DATA : IDLE;
            end
            RD_DATA: begin
                mem_resp_data_v_o = 1'b1;
                if (mem_resp_data_ready_i && last_beat)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            hdr_r <= '0;
            cnt   <= '0;
            for (int i = 0; i < els_p; i++)
                store[i] <= '0;
        end else begin
            state <= state_n;
            if (cmd_hdr_xfer) begin
                hdr_r <= mem_cmd_header_i;
                cnt   <= '0;
            end
            if (cmd_data_xfer) begin
                store[idx] <= mem_cmd_data_i;
                cnt        <= last_beat ? 5'd0 : cnt + 5'd1;
            end
            if (resp_hdr_xfer)
                cnt <= '0;
            if (resp_data_xfer)
                cnt <= last_beat ? 5'd0 : cnt + 5'd1;
        end
    end

endmodule

// File: doc/bp_me_burst_mem_responder.md
BP_ME_BURST_MEM_RESPONDER -- requirements
Module: bp_me_burst_mem_responder

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, physical address width.
REQ-002 SHALL have parameter dword_width_p, default 64, data beat width.
REQ-003 SHALL have parameter payload_width_p, default 16, opaque header payload returned unchanged.
REQ-004 SHALL have parameter els_p, default 64, dword entries in backing store (power of 2).
REQ-005 SHALL use header layout, LSB first: msg_type[3:0], addr[paddr_width_p-1:0], size[2:0], payload[payload_width_p-1:0]; hdr_w = 7+paddr_width_p+payload_width_p.
REQ-006 clk_i  input  1  sole clock, rising edge.
REQ-007 reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 mem_cmd_header_i  input  hdr_w  command header.
REQ-009 mem_cmd_header_v_i / mem_cmd_header_ready_o  input/output  1/1  command header handshake.
REQ-010 mem_cmd_data_i  input  dword_width_p  write data beat.
REQ-011 mem_cmd_data_v_i / mem_cmd_data_ready_o  input/output  1/1  command data handshake.
REQ-012 mem_resp_header_o  output  hdr_w  response header.
REQ-013 mem_resp_header_v_o / mem_resp_header_ready_i  output/input  1/1  response header handshake.
REQ-014 mem_resp_data_o  output  dword_width_p  read data beat.
REQ-015 mem_resp_data_v_o / mem_resp_data_ready_i  output/input  1/1  response data handshake.

Function
REQ-016 Every handshake SHALL transfer only on a cycle where valid and ready are both high (ready&valid); valid, once raised, SHALL hold with stable data until transfer.
REQ-017 msg_type 0 = read, 1 = write; any other value SHALL be unsupported.
REQ-018 beats N SHALL equal 1 when size<=3, else 2^(size-3) (size 6 -> 8, size 7 -> 16).
REQ-019 Start index SHALL be addr[3+:log2(els_p)]; beat k SHALL use (start+k) mod els_p (wrap at end of store); addr[2:0] ignored.
REQ-020 FSM states: IDLE, WR_DATA, RESP_HDR, RD_DATA.
REQ-021 IDLE: mem_cmd_header_ready_o=1; on header transfer, latch header; write -> WR_DATA, read or unsupported -> RESP_HDR.
REQ-022 mem_cmd_header_ready_o SHALL be 1 only in IDLE; mem_cmd_data_ready_o only in WR_DATA.
REQ-023 WR_DATA: each data transfer SHALL write the beat into store[index] that edge and advance a beat counter; after beat N-1 -> RESP_HDR.
REQ-024 RESP_HDR: mem_resp_header_v_o=1; mem_resp_header_o SHALL equal latched header unchanged; on transfer, read -> RD_DATA (counter cleared), otherwise -> IDLE.
REQ-025 RD_DATA: mem_resp_data_v_o=1, mem_resp_data_o=store[index of current beat] (combinational from storage); each transfer advances counter; after beat N-1 -> IDLE.
REQ-026 Unsupported types SHALL consume no data beats, SHALL not modify the store, and SHALL return header only.
REQ-027 Latency: resp header valid SHALL be asserted the cycle after last cmd transfer (header for read, final data beat for write); first read beat valid the cycle after resp header transfer.
REQ-028 Data valid/ready deasserted mid-burst SHALL stall without losing or repeating beats; a cmd data beat presented outside WR_DATA SHALL not be consumed.
REQ-029 Only one command SHALL be outstanding; next header accepted no earlier than the cycle after the response completes.

Reset
REQ-030 While reset_n_i=0: state=IDLE, counter=0, latched header=0, all store entries=0, mem_resp_header_v_o=0, mem_resp_data_v_o=0, mem_cmd_data_ready_o=0, mem_cmd_header_ready_o=0.
REQ-031 Reset assertion mid-burst SHALL abort immediately (asynchronously) with no further store writes; mem_cmd_header_ready_o=1 from the first edge after release.

Verification
REQ-032 Write size=3 addr 0x10 data 0xDEAD_BEEF, then read size=3 addr 0x10 -> write resp header only; read resp header then one beat 0xDEAD_BEEF; payloads echoed.
REQ-033 Write size=6 addr 0x40 beats 0..7 = 0x100+k, read back with mem_resp_data_ready_i toggled every other cycle -> 8 beats 0x100..0x107 in order, no duplicates.
REQ-034 Write size=6 addr (els_p-2)*8 beats 0xA0..0xA7, read size=3 addr 0 -> returns 0xA2 (wrap).
REQ-035 Header msg_type=5 with data valid held high -> header-only response, zero data beats consumed, store unchanged.
REQ-036 Assert reset_n_i after 3 of 8 write beats, release, read same addr -> all zeros; valids low during reset.
REQ-037 Read immediately after reset with mem_resp_header_ready_i=0 for 5 cycles -> resp header valid held stable 5 cycles, mem_cmd_header_ready_o=0 throughout.
